if_fetch_buffer: RTL and testbench

//  Decoupling queue between the IFU (fetch stage) and the decode stage of the pipelined MIPS core.

---
 rtl/if_fetch_buffer.sv | 141 ++++++++++++++
 tb/tb_if_fetch_buffer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_buffer.sv
// Purpose: in-order {pc, instr} queue decoupling the IFU from decode, valid/ready on both sides.
// Latency: a word pushed in cycle N is presented on d_* in cycle N+1; no f->d bypass.
// Backpressure: f_ready (IFU pc_en) drops while full and only rises the cycle after a pop.
// Option: define FETCH_BUF_EXC_EN to tag each word with an AdEL ExcCode on the d_exc port.
module if_fetch_buffer #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter logic [31:0] IM_SIZE  = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        f_valid,
  input  logic [31:0] f_pc,
  input  logic [31:0] f_instr,
  output logic        f_ready,
  output logic        d_valid,
  input  logic        d_ready,
  output logic [31:0] d_pc,
  output logic [31:0] d_pc8,
  output logic [31:0] d_instr,
  input  logic        flush
`ifdef FETCH_BUF_EXC_EN
  ,
  output logic [4:0]  d_exc
`endif
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Slot storage: one pc and one instruction per entry.
  logic [31:0] pc_q    [DEPTH];
  logic [31:0] instr_q [DEPTH];

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic push;
  logic pop;

  // Word actually written into a slot (may be squashed by the address check).
  logic [31:0] wr_instr;

`ifdef FETCH_BUF_EXC_EN
  localparam logic [32:0] IM_END = {1'b0, IM_BASE} + {1'b0, IM_SIZE};
  localparam logic [4:0]  EXC_ADEL = 5'd4;

  logic [4:0] exc_q [DEPTH];
  logic       pc_bad;
  logic [4:0] wr_exc;

  // Misaligned or out-of-window fetch address raises AdEL and the word becomes a nop.
  always_comb begin
    pc_bad   = 1'b0;
    wr_exc   = 5'd0;
    wr_instr = f_instr;
    if ((f_pc[1:0] != 2'b00) || (f_pc < IM_BASE) || ({1'b0, f_pc} >= IM_END)) begin
      pc_bad = 1'b1;
    end
    if (pc_bad) begin
      wr_exc   = EXC_ADEL;
      wr_instr = 32'h0;
    end
  end
`else
  // Without the exception option the address window is never consulted.
  logic unused_cfg;
  assign unused_cfg = ^{IM_BASE, IM_SIZE};

  // Fetched word is stored unmodified.
  always_comb begin
    wr_instr = f_instr;
  end
`endif

  // Handshake qualifiers; a full buffer refuses a push even if it pops this cycle.
  always_comb begin
    f_ready = (count != FULL_CNT);
    d_valid = (count != '0);
    push    = f_valid & f_ready;
    pop     = d_valid & d_ready;
  end

  // Pointer and occupancy control: reset beats flush, flush beats push/pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Slot write on push; a flush leaves existing slot contents untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= RESET_PC;
        instr_q[i] <= 32'h0;
`ifdef FETCH_BUF_EXC_EN
        exc_q[i]   <= 5'd0;
`endif
      end
    end else if (!flush && push) begin
      pc_q[wr_ptr]    <= f_pc;
      instr_q[wr_ptr] <= wr_instr;
`ifdef FETCH_BUF_EXC_EN
      exc_q[wr_ptr]   <= wr_exc;
`endif
    end
  end

  // Head presentation: pc fields always show the slot, instr/exc read as zero when empty.
  always_comb begin
    d_pc    = pc_q[rd_ptr];
    d_pc8   = pc_q[rd_ptr] + 32'd8;
    d_instr = d_valid ? instr_q[rd_ptr] : 32'h0;
`ifdef FETCH_BUF_EXC_EN
    d_exc   = d_valid ? exc_q[rd_ptr] : 5'd0;
`endif
  end

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Directed bench for if_fetch_buffer: fill/full, pop-while-full, streaming wrap,
// flush, reset priority, and (with FETCH_BUF_EXC_EN) the AdEL tagging.
module tb_if_fetch_buffer;

  logic        clk;
  logic        reset;
  logic        f_valid;
  logic [31:0] f_pc;
  logic [31:0] f_instr;
  logic        f_ready;
  logic        d_valid;
  logic        d_ready;
  logic [31:0] d_pc;
  logic [31:0] d_pc8;
  logic [31:0] d_instr;
  logic        flush;
`ifdef FETCH_BUF_EXC_EN
  logic [4:0]  d_exc;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  if_fetch_buffer dut (
    .clk     (clk),
    .reset   (reset),
    .f_valid (f_valid),
    .f_pc    (f_pc),
    .f_instr (f_instr),
    .f_ready (f_ready),
    .d_valid (d_valid),
    .d_ready (d_ready),
    .d_pc    (d_pc),
    .d_pc8   (d_pc8),
    .d_instr (d_instr),
    .flush   (flush)
`ifdef FETCH_BUF_EXC_EN
    ,
    .d_exc   (d_exc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Distinct instruction word derived from its pc.
  function automatic logic [31:0] iw(input logic [31:0] pc);
    return {16'h2400, pc[15:0]};
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle past the edge before sampling.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_f(input logic v, input logic [31:0] pc);
    f_valid = v;
    f_pc    = pc;
    f_instr = iw(pc);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; d_ready = 1'b0;
    drive_f(1'b0, 32'h0);
    cyc();
    cyc();
    reset = 1'b0;

    // Reset state
    chk1 ("rst_d_valid", d_valid, 1'b0);
    chk1 ("rst_f_ready", f_ready, 1'b1);
    chk32("rst_d_pc",    d_pc,    32'h3000);
    chk32("rst_d_pc8",   d_pc8,   32'h3008);
    chk32("rst_d_instr", d_instr, 32'h0);
`ifdef FETCH_BUF_EXC_EN
    chk32("rst_d_exc", {27'b0, d_exc}, 32'h0);
`endif

    // 1: fill to full with decode stalled
    drive_f(1'b1, 32'h3000);
    cyc();
    chk1 ("t1_valid_after_1", d_valid, 1'b1);
    chk1 ("t1_ready_after_1", f_ready, 1'b1);
    chk32("t1_pc_after_1",    d_pc,    32'h3000);
    drive_f(1'b1, 32'h3004);
    cyc();
    chk1 ("t1_full_f_ready", f_ready, 1'b0);
    chk32("t1_head_pc",      d_pc,    32'h3000);
    chk32("t1_head_pc8",     d_pc8,   32'h3008);
    chk32("t1_head_instr",   d_instr, iw(32'h3000));
    drive_f(1'b1, 32'h3008);
    cyc();
    chk1 ("t1_held_full", f_ready, 1'b0);
    chk32("t1_held_head", d_pc,    32'h3000);

    // 2: pop while full, the offered word is not taken that cycle
    d_ready = 1'b1;
    cyc();
    chk32("t2_head_3004",  d_pc,    32'h3004);
    chk32("t2_instr_3004", d_instr, iw(32'h3004));
    chk1 ("t2_f_ready_up", f_ready, 1'b1);
    d_ready = 1'b0;
    cyc();
    chk1 ("t2_full_again", f_ready, 1'b0);
    chk32("t2_head_still", d_pc,    32'h3004);
    drive_f(1'b0, 32'h0);
    d_ready = 1'b1;
    cyc();
    chk32("t2_order_3008", d_pc,    32'h3008);
    chk32("t2_instr_3008", d_instr, iw(32'h3008));
    cyc();
    chk1 ("t2_empty_valid", d_valid, 1'b0);
    chk32("t2_empty_instr", d_instr, 32'h0);
    chk32("t2_empty_pc",    d_pc,    32'h3004);
    cyc();
    chk1 ("t2_empty_hold_valid", d_valid, 1'b0);
    chk32("t2_empty_hold_pc",    d_pc,    32'h3004);

    // 3: single occupant, then 8 words streaming through with push+pop each cycle
    d_ready = 1'b0;
    drive_f(1'b1, 32'h300c);
    cyc();
    chk32("t3_pre_pc", d_pc, 32'h300c);
    d_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive_f(1'b1, 32'h3010 + 32'(4 * k));
      cyc();
      chk32("t3_stream_pc",    d_pc,    32'h3010 + 32'(4 * k));
      chk32("t3_stream_instr", d_instr, iw(32'h3010 + 32'(4 * k)));
      chk1 ("t3_stream_ready", f_ready, 1'b1);
      chk1 ("t3_stream_valid", d_valid, 1'b1);
    end

    // 4: fill to two, then flush with a word incoming and a pop requested
    d_ready = 1'b0;
    drive_f(1'b1, 32'h3030);
    cyc();
    chk1 ("t4_full", f_ready, 1'b0);
    flush   = 1'b1;
    d_ready = 1'b1;
    drive_f(1'b1, 32'h3034);
    cyc();
    chk1 ("t4_flush_valid", d_valid, 1'b0);
    chk32("t4_flush_instr", d_instr, 32'h0);
    chk1 ("t4_flush_ready", f_ready, 1'b1);
    chk32("t4_flush_slot0", d_pc,    32'h3030);
    flush = 1'b0;
    drive_f(1'b0, 32'h0);
    cyc();
    chk1 ("t4_post_valid", d_valid, 1'b0);
    d_ready = 1'b0;
    drive_f(1'b1, 32'h3100);
    cyc();
    chk32("t4_refill_pc",    d_pc,    32'h3100);
    chk32("t4_refill_instr", d_instr, iw(32'h3100));

    // 5: reset together with flush and an incoming word
    reset = 1'b1;
    flush = 1'b1;
    drive_f(1'b1, 32'h3104);
    cyc();
    reset = 1'b0;
    flush = 1'b0;
    drive_f(1'b0, 32'h0);
    chk1 ("t5_valid", d_valid, 1'b0);
    chk32("t5_pc",    d_pc,    32'h3000);
    chk32("t5_pc8",   d_pc8,   32'h3008);
    chk1 ("t5_ready", f_ready, 1'b1);
    chk32("t5_instr", d_instr, 32'h0);

`ifdef FETCH_BUF_EXC_EN
    // 6: misaligned, above-window, last legal word
    d_ready = 1'b0;
    drive_f(1'b1, 32'h3002);
    cyc();
    chk32("t6_mis_exc",   {27'b0, d_exc}, 32'd4);
    chk32("t6_mis_instr", d_instr,        32'h0);
    d_ready = 1'b1;
    drive_f(1'b1, 32'h4000);
    cyc();
    chk32("t6_hi_pc",    d_pc,           32'h4000);
    chk32("t6_hi_exc",   {27'b0, d_exc}, 32'd4);
    chk32("t6_hi_instr", d_instr,        32'h0);
    drive_f(1'b1, 32'h3ffc);
    cyc();
    chk32("t6_ok_exc",   {27'b0, d_exc}, 32'd0);
    chk32("t6_ok_instr", d_instr,        iw(32'h3ffc));
    drive_f(1'b1, 32'h2ffc);
    cyc();
    chk32("t6_lo_exc", {27'b0, d_exc}, 32'd4);
    drive_f(1'b0, 32'h0);
    cyc();
    chk1 ("t6_empty_valid", d_valid,        1'b0);
    chk32("t6_empty_exc",   {27'b0, d_exc}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
